// File: rtl/cpu_pkg.sv
// Shared CPU definitions: FSM state encoding, counter width default and the
// pipeline-register control bundle used by the hazard controller.
package cpu_pkg;

    localparam int CNT_W_DEF = 32;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_e;

    typedef struct packed {
        logic pc_en;
        logic ifid_en;
        logic ifid_flush;
        logic idex_flush;
    } ctrl_t;

    // Named control patterns; HOLD freezes PC and IF/ID and injects one bubble into EX.
    localparam ctrl_t CTRL_RESET = '{pc_en: 1'b0, ifid_en: 1'b0, ifid_flush: 1'b1, idex_flush: 1'b1};
    localparam ctrl_t CTRL_HOLD  = '{pc_en: 1'b0, ifid_en: 1'b0, ifid_flush: 1'b0, idex_flush: 1'b1};
    localparam ctrl_t CTRL_SQUASH = '{pc_en: 1'b1, ifid_en: 1'b1, ifid_flush: 1'b1, idex_flush: 1'b1};
    localparam ctrl_t CTRL_JUMP  = '{pc_en: 1'b1, ifid_en: 1'b1, ifid_flush: 1'b1, idex_flush: 1'b0};
    localparam ctrl_t CTRL_RUN   = '{pc_en: 1'b1, ifid_en: 1'b1, ifid_flush: 1'b0, idex_flush: 1'b0};

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard/branch event inputs and pipeline-register control outputs of the
// hazard controller; master is the pipeline side, slave is the controller.
interface pipe_hazard_ctrl_if;

    logic load_use;
    logic ex_is_branch;
    logic ex_branch_taken;
    logic id_jump;
    logic halt_req;
    logic resume;
    logic pc_en;
    logic ifid_en;
    logic ifid_flush;
    logic idex_flush;
    logic halted;

    modport master (
        output load_use, ex_is_branch, ex_branch_taken, id_jump, halt_req, resume,
        input  pc_en, ifid_en, ifid_flush, idex_flush, halted
    );

    modport slave (
        input  load_use, ex_is_branch, ex_branch_taken, id_jump, halt_req, resume,
        output pc_en, ifid_en, ifid_flush, idex_flush, halted
    );

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-low clear; holds at all-ones.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: PC/IF-ID/ID-EX enables and flushes, RUN/HALT FSM
// and saturating performance counters. Define HALT_RESUME_EN to allow leaving HALT on resume.
module pipe_hazard_ctrl
    import cpu_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    pipe_hazard_ctrl_if.slave bus,
    output logic [CNT_W-1:0]  cycle_cnt,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  uncond_cnt,
    output logic [CNT_W-1:0]  cond_cnt,
    output logic [CNT_W-1:0]  cond_taken_cnt
);

    state_e state, state_nxt;
    ctrl_t  ctrl;
    logic   halted;
    logic   inc_cycle, inc_stall, inc_uncond, inc_cond, inc_taken;
    logic   br_taken;

    assign br_taken = bus.ex_is_branch & bus.ex_branch_taken;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: every variable written here gets a default first so no latch is inferred.
    always_comb begin
        state_nxt  = state;
        ctrl       = CTRL_RESET;
        halted     = 1'b0;
        inc_cycle  = 1'b0;
        inc_stall  = 1'b0;
        inc_uncond = 1'b0;
        inc_cond   = 1'b0;
        inc_taken  = 1'b0;

        if (rst_n) begin
            unique case (state)
                ST_RUN: begin
                    inc_cycle = 1'b1;
                    if (bus.halt_req) begin
                        ctrl      = CTRL_HOLD;
                        state_nxt = ST_HALT;
                    end else begin
                        inc_cond = bus.ex_is_branch;
                        // A taken branch squashes the ID instruction, so its stall/jump never applies.
                        if (br_taken) begin
                            ctrl      = CTRL_SQUASH;
                            inc_taken = 1'b1;
                        end else if (bus.load_use) begin
                            ctrl      = CTRL_HOLD;
                            inc_stall = 1'b1;
                        end else if (bus.id_jump) begin
                            ctrl       = CTRL_JUMP;
                            inc_uncond = 1'b1;
                        end else begin
                            ctrl = CTRL_RUN;
                        end
                    end
                end
                ST_HALT: begin
                    ctrl   = CTRL_HOLD;
                    halted = 1'b1;
`ifdef HALT_RESUME_EN
                    if (bus.resume) begin
                        state_nxt = ST_RUN;
                    end
`endif
                end
                default: state_nxt = ST_RUN;
            endcase
        end
    end

`ifndef HALT_RESUME_EN
    logic unused_resume;
    assign unused_resume = bus.resume;
`endif

    assign bus.pc_en      = ctrl.pc_en;
    assign bus.ifid_en    = ctrl.ifid_en;
    assign bus.ifid_flush = ctrl.ifid_flush;
    assign bus.idex_flush = ctrl.idex_flush;
    assign bus.halted     = halted;

    sat_counter #(.W(CNT_W)) u_cycle_cnt (
        .clk(clk), .rst_n(rst_n), .inc(inc_cycle), .cnt(cycle_cnt)
    );

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk(clk), .rst_n(rst_n), .inc(inc_stall), .cnt(stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_uncond_cnt (
        .clk(clk), .rst_n(rst_n), .inc(inc_uncond), .cnt(uncond_cnt)
    );

    sat_counter #(.W(CNT_W)) u_cond_cnt (
        .clk(clk), .rst_n(rst_n), .inc(inc_cond), .cnt(cond_cnt)
    );

    sat_counter #(.W(CNT_W)) u_cond_taken_cnt (
        .clk(clk), .rst_n(rst_n), .inc(inc_taken), .cnt(cond_taken_cnt)
    );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench: two controllers (32-bit and 4-bit counters) share one
// stimulus stream and are compared every cycle against a behavioural model.
module tb_pipe_hazard_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pipe_hazard_ctrl_if bus();
    pipe_hazard_ctrl_if bus4();

    logic [31:0] cyc32, stl32, unc32, cnd32, tkn32;
    logic [3:0]  cyc4, stl4, unc4, cnd4, tkn4;

    pipe_hazard_ctrl #(.CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus),
        .cycle_cnt(cyc32), .stall_cnt(stl32), .uncond_cnt(unc32),
        .cond_cnt(cnd32), .cond_taken_cnt(tkn32)
    );

    pipe_hazard_ctrl #(.CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .bus(bus4),
        .cycle_cnt(cyc4), .stall_cnt(stl4), .uncond_cnt(unc4),
        .cond_cnt(cnd4), .cond_taken_cnt(tkn4)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: a halted flag and raw (unbounded) event totals.
    bit     m_halted = 1'b0;
    bit     m_valid  = 1'b0;
    longint m_cyc = 0, m_stl = 0, m_unc = 0, m_cnd = 0, m_tkn = 0;

    function automatic longint sat(input longint v, input int w);
        longint mx;
        mx = (longint'(1) << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    always @(negedge clk) begin
        bit e_pc, e_ifid, e_iff, e_idf, e_halt;
        bit lu, br, tk, jp, hr, rs;
        lu = bus.load_use; br = bus.ex_is_branch; tk = bus.ex_branch_taken;
        jp = bus.id_jump;  hr = bus.halt_req;     rs = bus.resume;

        if (!rst_n)              {e_pc, e_ifid, e_iff, e_idf, e_halt} = 5'b00110;
        else if (m_halted)       {e_pc, e_ifid, e_iff, e_idf, e_halt} = 5'b00011;
        else if (hr)             {e_pc, e_ifid, e_iff, e_idf, e_halt} = 5'b00010;
        else if (br && tk)       {e_pc, e_ifid, e_iff, e_idf, e_halt} = 5'b11110;
        else if (lu)             {e_pc, e_ifid, e_iff, e_idf, e_halt} = 5'b00010;
        else if (jp)             {e_pc, e_ifid, e_iff, e_idf, e_halt} = 5'b11100;
        else                     {e_pc, e_ifid, e_iff, e_idf, e_halt} = 5'b11000;

        check("pc_en",       bus.pc_en,      e_pc);
        check("ifid_en",     bus.ifid_en,    e_ifid);
        check("ifid_flush",  bus.ifid_flush, e_iff);
        check("idex_flush",  bus.idex_flush, e_idf);
        check("halted",      bus.halted,     e_halt);
        check("pc_en_w4",    bus4.pc_en,     e_pc);
        check("halted_w4",   bus4.halted,    e_halt);

        if (m_valid) begin
            check("cycle_cnt",      cyc32, sat(m_cyc, 32));
            check("stall_cnt",      stl32, sat(m_stl, 32));
            check("uncond_cnt",     unc32, sat(m_unc, 32));
            check("cond_cnt",       cnd32, sat(m_cnd, 32));
            check("cond_taken_cnt", tkn32, sat(m_tkn, 32));
            check("cycle_cnt_w4",   cyc4,  sat(m_cyc, 4));
            check("stall_cnt_w4",   stl4,  sat(m_stl, 4));
            check("uncond_cnt_w4",  unc4,  sat(m_unc, 4));
            check("cond_cnt_w4",    cnd4,  sat(m_cnd, 4));
            check("cond_taken_w4",  tkn4,  sat(m_tkn, 4));
        end

        // Advance the model to the state after the coming rising edge.
        if (!rst_n) begin
            m_halted = 1'b0;
            m_valid  = 1'b1;
            m_cyc = 0; m_stl = 0; m_unc = 0; m_cnd = 0; m_tkn = 0;
        end else if (m_halted) begin
`ifdef HALT_RESUME_EN
            if (rs) m_halted = 1'b0;
`endif
        end else begin
            m_cyc++;
            if (hr) begin
                m_halted = 1'b1;
            end else begin
                if (br) m_cnd++;
                if (br && tk) m_tkn++;
                else if (lu) m_stl++;
                else if (jp) m_unc++;
            end
        end
    end

    task automatic drive(input bit lu, input bit br, input bit tk, input bit jp, input bit hr, input bit rs);
        bus.load_use  = lu; bus.ex_is_branch  = br; bus.ex_branch_taken  = tk;
        bus.id_jump   = jp; bus.halt_req      = hr; bus.resume           = rs;
        bus4.load_use = lu; bus4.ex_is_branch = br; bus4.ex_branch_taken = tk;
        bus4.id_jump  = jp; bus4.halt_req     = hr; bus4.resume          = rs;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        drive(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        drive(0, 0, 0, 0, 0, 0);

        // Reset held two cycles, controls forced while asserted.
        rst_n = 1'b0;
        tick();
        check("lit_rst_pc_en",      bus.pc_en, 1'b0);
        check("lit_rst_ifid_flush", bus.ifid_flush, 1'b1);
        check("lit_rst_idex_flush", bus.idex_flush, 1'b1);
        tick();
        rst_n = 1'b1;
        #1;
        check("lit_post_rst_pc_en", bus.pc_en, 1'b1);
        check("lit_post_rst_cycle", cyc32, 0);
        check("lit_post_rst_stall", stl32, 0);

        // Single and back-to-back load-use stalls.
        drive(1, 0, 0, 0, 0, 0); tick();
        idle(1);
        drive(1, 0, 0, 0, 0, 0); tick();
        drive(1, 0, 0, 0, 0, 0); tick();
        idle(1);
        check("lit_stall_cnt_3", stl32, 3);

        // Taken branch overrides simultaneous load-use and jump.
        do_reset();
        drive(1, 1, 1, 1, 0, 0);
        #1;
        check("lit_squash_pc_en",      bus.pc_en, 1'b1);
        check("lit_squash_ifid_flush", bus.ifid_flush, 1'b1);
        check("lit_squash_idex_flush", bus.idex_flush, 1'b1);
        tick();
        idle(1);
        check("lit_squash_cond",   cnd32, 1);
        check("lit_squash_taken",  tkn32, 1);
        check("lit_squash_stall",  stl32, 0);
        check("lit_squash_uncond", unc32, 0);

        // Load-use holds a pending jump for one cycle.
        do_reset();
        drive(1, 0, 0, 1, 0, 0); tick();
        drive(0, 0, 0, 1, 0, 0);
        #1;
        check("lit_held_jump_ifid_flush", bus.ifid_flush, 1'b1);
        tick();
        idle(1);
        check("lit_held_jump_stall",  stl32, 1);
        check("lit_held_jump_uncond", unc32, 1);

        // Halt after 10 RUN cycles, idle, then resume pulse.
        do_reset();
        idle(10);
        drive(0, 0, 0, 0, 1, 0); tick();
        idle(5);
        check("lit_halted",      bus.halted, 1'b1);
        check("lit_halt_cycles", cyc32, 11);
        drive(0, 0, 0, 0, 0, 1); tick();
        idle(1);
`ifdef HALT_RESUME_EN
        check("lit_resumed", bus.halted, 1'b0);
`else
        check("lit_still_halted", bus.halted, 1'b1);
`endif

        // Narrow counter saturation.
        do_reset();
        idle(20);
        check("lit_sat_w4_cycle", cyc4, 15);
        check("lit_sat_w32_cycle", cyc32, 20);

        // Randomized traffic with occasional halts, resumes and resets.
        do_reset();
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 59) == 0) begin
                do_reset();
            end else begin
                drive($urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 0,
                      $urandom_range(0, 3) == 0, $urandom_range(0, 29) == 0, $urandom_range(0, 5) == 0);
                tick();
            end
        end
        idle(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Consumes the hazard detector's load-use stall request and the branch/jump/halt events of the 5-stage MIPS pipeline.
- Turns them into the per-cycle enable and flush controls for the PC register, IF/ID register and ID/EX register.
- Runs a RUN/HALT state machine for syscall halt.
- Keeps saturating performance counters for cycles, load-use stalls, unconditional jumps, conditional branches and taken branches.
- Sits between the hazard detector and the pipeline registers in the CPU top level.

Parameters:
- CNT_W, 32, width of every performance counter.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- load_use  in  1  load-use hazard request from hazard detector (ID instruction needs EX load result).
- ex_is_branch  in  1  conditional branch instruction currently in EX.
- ex_branch_taken  in  1  conditional branch in EX resolved taken; only meaningful with ex_is_branch=1.
- id_jump  in  1  unconditional jump (J/JAL/JR) decoded in ID.
- halt_req  in  1  halt syscall currently in EX.
- resume  in  1  external continue request (one-cycle or level).
- pc_en  out  1  PC register load enable.
- ifid_en  out  1  IF/ID register load enable.
- ifid_flush  out  1  IF/ID register clear to NOP at next edge.
- idex_flush  out  1  ID/EX register clear to bubble at next edge.
- halted  out  1  state==HALT.
- cycle_cnt  out  CNT_W  RUN cycles executed.
- stall_cnt  out  CNT_W  load-use stall cycles applied.
- uncond_cnt  out  CNT_W  unconditional jumps taking effect.
- cond_cnt  out  CNT_W  conditional branches executed.
- cond_taken_cnt  out  CNT_W  conditional branches taken.

Behaviour:
- Clock port is clk; reset port is rst_n. One clock; reset is synchronous and active-low.
- State register: RUN or HALT. Counters are registered. All control outputs are combinational from the current state and inputs.
- While rst_n=0 (combinational):
  - pc_en=0, ifid_en=0, ifid_flush=1, idex_flush=1, halted=0.
  - At the edge: state<=RUN and all counters<=0.
- RUN, priority high to low, first matching row applies:
  1. halt_req: pc_en=0, ifid_en=0, ifid_flush=0, idex_flush=1. Next state HALT.
  2. ex_is_branch & ex_branch_taken: pc_en=1, ifid_en=1, ifid_flush=1, idex_flush=1. load_use and id_jump are ignored because their instructions are squashed.
  3. load_use: pc_en=0, ifid_en=0, ifid_flush=0, idex_flush=1 (one bubble). A pending id_jump is held and takes effect in a later cycle.
  4. id_jump: pc_en=1, ifid_en=1, ifid_flush=1, idex_flush=0.
  5. Default: pc_en=1, ifid_en=1, both flushes 0.
- HALT:
  - pc_en=0, ifid_en=0, ifid_flush=0, idex_flush=1, halted=1. All other inputs are ignored.
  - resume=1 gives next state RUN; controls stay halted during that cycle.
  - IF/ID contents are preserved across the halt.
- Counters (all saturate at 2^CNT_W-1, no wrap; none change while rst_n=0):
  - cycle_cnt: +1 every edge with state RUN, including the halt_req cycle.
  - stall_cnt: +1 when row 3 applies.
  - uncond_cnt: +1 when row 4 applies.
  - cond_cnt: +1 when in RUN with ex_is_branch=1 and no halt_req.
  - cond_taken_cnt: +1 when row 2 applies.
- Back-to-back load_use cycles each stall and each count.
- ex_branch_taken without ex_is_branch is treated as no branch.

Optional Feature:
- Macro HALT_RESUME_EN.
- Defined: HALT exits to RUN on resume as described above.
- Undefined: resume is ignored and HALT is terminal until rst_n=0. The resume port remains present but unused.

Decomposition:
- Shared package cpu_pkg holds:
  - state encoding constants ST_RUN=1'b0, ST_HALT=1'b1;
  - CNT_W default;
  - a typedef for the control bundle {pc_en, ifid_en, ifid_flush, idex_flush}.
- One natural sub-module: sat_counter (parameter W; inputs clk, rst_n, inc; output cnt), instantiated five times.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles -> pc_en=0, ifid_flush=1, idex_flush=1; after release all counters=0 and pc_en=1.
- load_use=1 for 1 cycle, then 2 consecutive cycles -> pc_en=0, ifid_en=0, idex_flush=1 in exactly those cycles; stall_cnt=3.
- ex_is_branch=ex_branch_taken=load_use=id_jump=1 in the same cycle -> ifid_flush=1, idex_flush=1, pc_en=1; cond_cnt=1, cond_taken_cnt=1, stall_cnt=0, uncond_cnt=0.
- load_use=1 with id_jump=1 for one cycle, then id_jump alone -> stall first cycle (stall_cnt=1), jump flush second cycle (uncond_cnt=1).
- halt_req=1 after 10 RUN cycles, then 5 idle cycles, then resume pulse -> halted=1 from the next cycle; cycle_cnt frozen at 11; RUN resumes one cycle after resume. Without HALT_RESUME_EN, halted stays 1.
- Force counters near saturation (CNT_W=4), run 20 cycles -> cycle_cnt holds at 15.
